hsi_monitor_frame_parser: RTL
=============================

# hsi_monitor_frame_parser

Receive-side counterpart of the HSI monitor frame path. Consumes the monitor byte stream (sync bytes 0x5E 0x4D, source address, 11-bit length, payload), validates the header, and writes payload bytes into the downstream monitor FIFO. It reports per-frame source, length, completion and error status to the HSI control logic.

## Interface
- TIMEOUT, 1024, max idle clk cycles between bytes inside a frame before abort; range 2..65535
- clk  in  1  clock
- n_rst  in  1  asynchronous, active-low reset
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- wrfull  in  1  FIFO full flag
- wrreq  out  1  FIFO write strobe
- q  out  8  FIFO write data
- busy  out  1  high in any state other than IDLE
- frame_src  out  1  0 = master monitor (0x0B), 1 = slave monitor (0x09); held until next ADDR
- frame_len  out  11  length from header; held until next LEN_L
- frame_done  out  1  one-cycle pulse, frame completed
- err_addr  out  1  one-cycle pulse, bad address byte
- err_len  out  1  one-cycle pulse, LEN_H[7:3] != 0
- err_ovf  out  1  sticky per frame, payload byte dropped on wrfull; cleared at next valid SYNC1
- err_tmo  out  1  one-cycle pulse, inter-byte timeout

## Operation
- States: IDLE, SYNC1, ADDR, LEN_H, LEN_L, PAYLOAD. Transitions occur only on rx_valid, except timeout.
- IDLE: byte 0x5E -> SYNC1; other bytes are ignored.
- SYNC1: 0x4D -> ADDR and clear err_ovf; 0x5E -> stay in SYNC1; other -> IDLE.
- ADDR: 0x0B -> frame_src=0; 0x09 -> frame_src=1; both go to LEN_H. Other -> pulse err_addr, go to IDLE.
- LEN_H: bits[7:3] != 0 -> pulse err_len, go to IDLE. Otherwise latch bits[2:0] as len[10:8] and go to LEN_L.
- LEN_L: latch len[7:0] and update frame_len. len == 0 -> pulse frame_done, go to IDLE. Else load remaining count = len, go to PAYLOAD.
- PAYLOAD: each byte decrements the count. Byte written (wrreq, q) if wrfull=0. If wrfull=1, drop the byte and set err_ovf; the count still decrements. Count reaching 0 -> frame_done, go to IDLE.
- Timeout: a counter runs in every non-IDLE state and resets on each rx_valid. Reaching TIMEOUT -> pulse err_tmo, go to IDLE, no frame_done.
- Timeout and rx_valid in the same cycle: the byte wins; the counter resets.
- Sync bytes inside PAYLOAD are ordinary data; no resync mid-frame.

## Timing
- All outputs registered. Reset values: wrreq=0, q=0, busy=0, frame_src=0, frame_len=0, frame_done=0, all err_*=0, state IDLE, counters 0.
- Payload byte sampled at edge N -> wrreq=1 and q=byte during cycle N+1, single cycle.
- Last payload byte: frame_done high in the same cycle as its wrreq.
- Zero-length frame: frame_done in the cycle after LEN_L is sampled.
- Error pulses: the cycle after the offending byte is sampled, or after the timeout count is reached. busy falls in that same cycle.
- Back-to-back rx_valid every cycle sustained at 1 byte/clk, no stall. A new 0x5E in the cycle after the last payload byte is accepted, because the state is already IDLE.
- Reset mid-frame: immediate return to reset values. A partially written frame is left in the FIFO; the FIFO owner flushes it.

## Structure
- Shared package hsi_monitor_pkg: SYNC0=8'h5E, SYNC1=8'h4D, MSTR_MNTR_ADDR=8'h0B, SLV_MNTR_ADDR=8'h09, parser state enum, LEN_W=11. The existing monitor reader also migrates to these constants.
- One sub-module: hsi_byte_timeout, a counter with clear, enable, TIMEOUT parameter and single-cycle expire output.
- Remaining logic (FSM, length counter, output registers) lives in the top module.

## Test plan
- Frame 5E 4D 0B 00 03 AA BB CC at 1 byte/clk -> three wrreq with q=AA,BB,CC; frame_src=0; frame_len=3; frame_done with CC.
- Slave frame 5E 4D 09 00 00 -> frame_src=1, frame_len=0, frame_done one cycle after 00, no wrreq.
- Noise 11 5E 5E 4D 0A -> err_addr pulse, IDLE, no wrreq. Then 5E 4D 0B 08 00 -> err_len pulse.
- Frame with len=2047 and wrfull forced high during bytes 100..109 -> 2037 wrreq, err_ovf=1, frame_done at byte 2047.
- TIMEOUT=16, frame stalls after LEN_L -> err_tmo exactly 16 cycles after last rx_valid. Stall of 15 cycles with rx_valid on the 16th -> no timeout.
- n_rst asserted mid-PAYLOAD -> all outputs at reset values. Next clean frame parses correctly.

Source files
------------

// File: rtl/hsi_monitor_pkg.sv
// Shared constants and types for the HSI monitor frame path. The monitor
// reader and the receive-side frame parser both take their constants from here.
package hsi_monitor_pkg;

  localparam logic [7:0] SYNC0          = 8'h5E;
  localparam logic [7:0] SYNC1          = 8'h4D;
  localparam logic [7:0] MSTR_MNTR_ADDR = 8'h0B;
  localparam logic [7:0] SLV_MNTR_ADDR  = 8'h09;
  localparam int         LEN_W          = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC1,
    ST_ADDR,
    ST_LEN_H,
    ST_LEN_L,
    ST_PAYLOAD
  } parser_state_t;

  // The high length byte carries only len[10:8]; any higher bit set is illegal.
  function automatic logic len_hi_ok(input logic [7:0] b);
    return (b[7:3] == 5'd0);
  endfunction

endpackage

// File: rtl/hsi_monitor_frame_parser_if.sv
// Byte stream in / monitor FIFO write out for the frame parser.
// master drives the received bytes and the FIFO full flag; slave is the parser.
interface hsi_monitor_frame_parser_if;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       wrfull;
  logic       wrreq;
  logic [7:0] q;

  modport master (output rx_valid, rx_data, wrfull, input wrreq, q);
  modport slave  (input rx_valid, rx_data, wrfull, output wrreq, q);

endinterface

// File: rtl/hsi_byte_timeout.sv
// Inter-byte idle counter. expire is high for the single cycle in which the
// count would reach TIMEOUT; a clear in that same cycle suppresses it.
module hsi_byte_timeout #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [15:0] count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= 16'd0;
    end else if (clr || !en) begin
      count <= 16'd0;
    end else begin
      count <= count + 16'd1;
    end
  end

  assign expire = en && !clr && (count == 16'(TIMEOUT - 1));

endmodule

// File: rtl/hsi_monitor_frame_parser.sv
// Receive-side HSI monitor frame parser: validates sync/address/length header,
// forwards payload bytes to the monitor FIFO and reports per-frame status.
module hsi_monitor_frame_parser
  import hsi_monitor_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     n_rst,
  hsi_monitor_frame_parser_if.slave bus,
  output logic                     busy,
  output logic                     frame_src,
  output logic [LEN_W-1:0]         frame_len,
  output logic                     frame_done,
  output logic                     err_addr,
  output logic                     err_len,
  output logic                     err_ovf,
  output logic                     err_tmo
);

  parser_state_t    state;
  logic [2:0]       len_hi;
  logic [LEN_W-1:0] remaining;
  logic             timer_en;
  logic             tmo_expire;

  assign timer_en = (state != ST_IDLE);

  hsi_byte_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr    (bus.rx_valid),
    .en     (timer_en),
    .expire (tmo_expire)
  );

  // A received byte always takes priority over a timeout landing in the same cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      len_hi     <= 3'd0;
      remaining  <= '0;
      bus.wrreq  <= 1'b0;
      bus.q      <= 8'h00;
      busy       <= 1'b0;
      frame_src  <= 1'b0;
      frame_len  <= '0;
      frame_done <= 1'b0;
      err_addr   <= 1'b0;
      err_len    <= 1'b0;
      err_ovf    <= 1'b0;
      err_tmo    <= 1'b0;
    end else begin
      bus.wrreq  <= 1'b0;
      frame_done <= 1'b0;
      err_addr   <= 1'b0;
      err_len    <= 1'b0;
      err_tmo    <= 1'b0;

      if (bus.rx_valid) begin
        case (state)
          ST_IDLE: begin
            if (bus.rx_data == SYNC0) begin
              state <= ST_SYNC1;
              busy  <= 1'b1;
            end
          end

          // A repeated first sync byte keeps us hunting for the second one.
          ST_SYNC1: begin
            if (bus.rx_data == SYNC1) begin
              state   <= ST_ADDR;
              err_ovf <= 1'b0;
            end else if (bus.rx_data != SYNC0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end

          ST_ADDR: begin
            if (bus.rx_data == MSTR_MNTR_ADDR) begin
              frame_src <= 1'b0;
              state     <= ST_LEN_H;
            end else if (bus.rx_data == SLV_MNTR_ADDR) begin
              frame_src <= 1'b1;
              state     <= ST_LEN_H;
            end else begin
              err_addr <= 1'b1;
              state    <= ST_IDLE;
              busy     <= 1'b0;
            end
          end

          ST_LEN_H: begin
            if (len_hi_ok(bus.rx_data)) begin
              len_hi <= bus.rx_data[2:0];
              state  <= ST_LEN_L;
            end else begin
              err_len <= 1'b1;
              state   <= ST_IDLE;
              busy    <= 1'b0;
            end
          end

          ST_LEN_L: begin
            frame_len <= {len_hi, bus.rx_data};
            if ({len_hi, bus.rx_data} == 11'd0) begin
              frame_done <= 1'b1;
              state      <= ST_IDLE;
              busy       <= 1'b0;
            end else begin
              remaining <= {len_hi, bus.rx_data};
              state     <= ST_PAYLOAD;
            end
          end

          // Dropped bytes still consume length so the frame boundary is kept.
          ST_PAYLOAD: begin
            if (!bus.wrfull) begin
              bus.wrreq <= 1'b1;
              bus.q     <= bus.rx_data;
            end else begin
              err_ovf <= 1'b1;
            end
            remaining <= remaining - 11'd1;
            if (remaining == 11'd1) begin
              frame_done <= 1'b1;
              state      <= ST_IDLE;
              busy       <= 1'b0;
            end
          end

          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (tmo_expire) begin
        err_tmo <= 1'b1;
        state   <= ST_IDLE;
        busy    <= 1'b0;
      end
    end
  end

endmodule
